// File: rtl/tx_desc_queue.sv
// TX descriptor queue: accepts {addr,len} via req/ack, drops bad lengths,
// buffers descriptors in a circular FIFO and serves them FWFT on valid/ready.
module tx_desc_queue #(
   parameter int NB_TX_DESC = 64,
   parameter int MAX_LEN    = 2047
) (
   input  logic                          axi_clk,
   input  logic                          axi_areset,
   input  logic                          init_i,
   input  logic [31:0]                   pkt_addr_i,
   input  logic [15:0]                   pkt_len_i,
   input  logic                          xmit_req_i,
   output logic                          xmit_ack_o,
   output logic [31:0]                   m_desc_addr,
   output logic [15:0]                   m_desc_len,
   output logic                          m_desc_valid,
   input  logic                          m_desc_ready,
   output logic [$clog2(NB_TX_DESC):0]   occupancy_o,
   output logic [31:0]                   drop_cnt_o,
   output logic [31:0]                   pkt_cnt_o
);

   localparam int               PW        = $clog2(NB_TX_DESC);
   localparam int               OW        = PW + 1;
   localparam logic [OW-1:0]    DEPTH     = OW'(NB_TX_DESC);
   localparam logic [15:0]      W_MAX_LEN = 16'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT_DROP} state_t;

   state_t          r_state;
   logic            r_ack;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [OW-1:0]   r_occ;
   logic            r_valid;
   logic [31:0]     r_addr;
   logic [15:0]     r_len;
   logic [31:0]     r_drop;
   logic [31:0]     r_pkt;
   logic [47:0]     r_mem [NB_TX_DESC];

   logic            w_full;
   logic            w_accept;
   logic            w_len_ok;
   logic            w_enq;
   logic            w_drop;
   logic            w_deq;
   logic [PW-1:0]   w_rd_next;
   logic [OW-1:0]   w_occ_left;
   logic [OW-1:0]   w_occ_next;

   assign w_full     = (r_occ == DEPTH);
   assign w_accept   = (r_state == S_IDLE) & xmit_req_i & ~r_ack & ~w_full & ~init_i;
   assign w_len_ok   = (pkt_len_i != 16'd0) && (pkt_len_i <= W_MAX_LEN);
   assign w_enq      = w_accept & w_len_ok;
   assign w_drop     = w_accept & ~w_len_ok;
   assign w_deq      = r_valid & m_desc_ready;
   assign w_rd_next  = r_rd_ptr + PW'(w_deq);
   assign w_occ_left = r_occ - OW'(w_deq);
   assign w_occ_next = w_occ_left + OW'(w_enq);

   // Ack handshake: one accept per request, wait for req to drop before re-arming.
   always_ff @(posedge axi_clk or posedge axi_areset) begin
      if (axi_areset) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
      end else if (init_i) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_ACK;
                  r_ack   <= 1'b1;
               end
            end
            S_ACK: begin
               r_state <= S_WAIT_DROP;
               r_ack   <= 1'b0;
            end
            S_WAIT_DROP: begin
               if (!xmit_req_i) r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_ack   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge axi_clk) begin
      if (w_enq) r_mem[r_wr_ptr] <= {pkt_addr_i, pkt_len_i};
   end

   // Head register is loaded only from entries already in storage, so an
   // enqueue into an empty queue shows up one cycle after it is written.
   always_ff @(posedge axi_clk or posedge axi_areset) begin
      if (axi_areset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_valid  <= 1'b0;
         r_addr   <= '0;
         r_len    <= '0;
         r_drop   <= '0;
         r_pkt    <= '0;
      end else if (init_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_valid  <= 1'b0;
         r_drop   <= '0;
         r_pkt    <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_pkt    <= r_pkt + 32'd1;
         end
         if (w_drop && (r_drop != '1)) r_drop <= r_drop + 32'd1;
         r_rd_ptr <= w_rd_next;
         r_occ    <= w_occ_next;
         r_valid  <= (w_occ_left != '0);
         if (w_occ_left != '0) {r_addr, r_len} <= r_mem[w_rd_next];
      end
   end

   assign xmit_ack_o   = r_ack;
   assign m_desc_addr  = r_addr;
   assign m_desc_len   = r_len;
   assign m_desc_valid = r_valid;
   assign occupancy_o  = r_occ;
   assign drop_cnt_o   = r_drop;
   assign pkt_cnt_o    = r_pkt;

endmodule
